timer_ctrl: RTL and testbench

TIMER_CTRL -- requirements
Module: timer_ctrl

---
 rtl/timer_ctrl_if.sv | 28 ++
 rtl/timer_ctrl.sv | 142 ++++++++++++++
 tb/tb_timer_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/timer_ctrl_if.sv
// Control/preset/display bundle for the MM:SS countdown timer.
// The master drives the controls and presets, and the slave (timer_ctrl) drives the display.
interface timer_ctrl_if;
  logic       start;
  logic       pause;
  logic       clear;
  logic [3:0] s1;
  logic [3:0] s2;
  logic [3:0] s3;
  logic [3:0] s4;
  logic [3:0] d1;
  logic [3:0] d2;
  logic [3:0] d3;
  logic [3:0] d4;
  logic [1:0] state;
  logic       led;
  logic       err;

  modport master (
    output start, pause, clear, s1, s2, s3, s4,
    input  d1, d2, d3, d4, state, led, err
  );

  modport slave (
    input  start, pause, clear, s1, s2, s3, s4,
    output d1, d2, d3, d4, state, led, err
  );
endinterface

// File: rtl/timer_ctrl.sv
// BCD MM:SS countdown timer with a start/pause/clear FSM.
// A prescaler divides clk down to a one-second tick.
module timer_ctrl #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic         clk,
  input  logic         rst_n,
  timer_ctrl_if.slave  bus
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t        state_r;
  logic [15:0]   value_r;
  logic [PW-1:0] presc_r;
  logic          led_r;
  logic          err_r;

  logic [15:0]   preset_s;
  logic          preset_valid_s;
  logic          preset_zero_s;
  logic          tick_s;
  logic          last_s;
  logic [15:0]   value_dec_s;

  // One-second BCD decrement of {m10, m1, s10, s1}; zero saturates.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v == 16'h0000) begin
      r = 16'h0000;
    end else if (v[3:0] != 4'd0) begin
      r[3:0] = v[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (v[7:4] != 4'd0) begin
        r[7:4] = v[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd5;
        if (v[11:8] != 4'd0) begin
          r[11:8] = v[11:8] - 4'd1;
        end else begin
          r[11:8]  = 4'd9;
          r[15:12] = v[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign preset_s       = {bus.s4, bus.s3, bus.s2, bus.s1};
  assign preset_valid_s = (bus.s1 <= 4'd9) && (bus.s2 <= 4'd5) &&
                          (bus.s3 <= 4'd9) && (bus.s4 <= 4'd9);
  assign preset_zero_s  = (preset_s == 16'h0000);
  assign tick_s         = (state_r == RUN) && (presc_r == PRESC_MAX);
  assign last_s         = (value_r == 16'h0001);
  assign value_dec_s    = bcd_dec(value_r);

  // Control FSM, prescaler and display registers; clear overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      value_r <= 16'h0000;
      presc_r <= '0;
      led_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      err_r <= 1'b0;
      if (bus.clear) begin
        state_r <= IDLE;
        value_r <= 16'h0000;
        presc_r <= '0;
        led_r   <= 1'b0;
      end else begin
        case (state_r)
          IDLE, DONE: begin
            if (bus.start) begin
              if (!preset_valid_s) begin
                err_r <= 1'b1;
              end else if (preset_zero_s) begin
                state_r <= DONE;
                value_r <= 16'h0000;
                presc_r <= '0;
                led_r   <= 1'b1;
              end else begin
                state_r <= RUN;
                value_r <= preset_s;
                presc_r <= '0;
                led_r   <= 1'b0;
              end
            end
          end
          RUN: begin
            // A pause freezes the prescaler, so a resume finishes the interrupted second.
            if (tick_s) begin
              presc_r <= '0;
              value_r <= value_dec_s;
              if (last_s) begin
                state_r <= DONE;
                led_r   <= 1'b1;
              end else if (bus.pause) begin
                state_r <= PAUSE;
              end
            end else if (bus.pause) begin
              state_r <= PAUSE;
            end else begin
              presc_r <= presc_r + PW'(1);
            end
          end
          PAUSE: begin
            if (bus.start) begin
              state_r <= RUN;
            end
          end
          default: begin
            state_r <= IDLE;
            value_r <= 16'h0000;
            presc_r <= '0;
            led_r   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.d1    = value_r[3:0];
  assign bus.d2    = value_r[7:4];
  assign bus.d3    = value_r[11:8];
  assign bus.d4    = value_r[15:12];
  assign bus.state = state_r;
  assign bus.led   = led_r;
  assign bus.err   = err_r;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed scoreboard bench for timer_ctrl with TICK_DIV=4.
module tb_timer_ctrl;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  typedef struct {
    string       tag;
    logic [1:0]  st;
    logic [15:0] dig;
    logic        led;
    logic        err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;
  exp_t sb_q[$];

  timer_ctrl_if bus ();

  timer_ctrl #(.TICK_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_preset(input logic [15:0] p);
    bus.s4 = p[15:12];
    bus.s3 = p[11:8];
    bus.s2 = p[7:4];
    bus.s1 = p[3:0];
  endtask

  task automatic push(input string tag, input logic [1:0] st, input logic [15:0] dig,
                      input logic led, input logic err);
    exp_t e;
    e.tag = tag;
    e.st  = st;
    e.dig = dig;
    e.led = led;
    e.err = err;
    sb_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t        e;
    logic [15:0] obs;
    n_assert++;
    assert (sb_q.size() > 0) else begin
      n_fail++;
      $error("FAIL sb_empty observed=%0d expected>0", sb_q.size());
    end
    if (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      obs = {bus.d4, bus.d3, bus.d2, bus.d1};
      n_assert++;
      assert (bus.state === e.st) else begin
        n_fail++;
        $error("FAIL %s.state observed=%b expected=%b", e.tag, bus.state, e.st);
      end
      n_assert++;
      assert (obs === e.dig) else begin
        n_fail++;
        $error("FAIL %s.digits observed=%h expected=%h", e.tag, obs, e.dig);
      end
      n_assert++;
      assert (bus.led === e.led) else begin
        n_fail++;
        $error("FAIL %s.led observed=%b expected=%b", e.tag, bus.led, e.led);
      end
      n_assert++;
      assert (bus.err === e.err) else begin
        n_fail++;
        $error("FAIL %s.err observed=%b expected=%b", e.tag, bus.err, e.err);
      end
    end
  endtask

  task automatic expect_after(input string tag, input int n, input logic [1:0] st,
                              input logic [15:0] dig, input logic led, input logic err);
    push(tag, st, dig, led, err);
    tick_n(n);
    pop_check();
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.clear = 1'b0;
    set_preset(16'h0000);

    // Reset values hold before any clock edge.
    #2;
    push("rst", S_IDLE, 16'h0000, 1'b0, 1'b0);
    pop_check();
    #10;
    rst_n = 1'b1;
    expect_after("idle", 1, S_IDLE, 16'h0000, 1'b0, 1'b0);

    // Normal countdown from 01:02 down to DONE.
    set_preset(16'h0102);
    bus.start = 1'b1;
    expect_after("load", 1, S_RUN, 16'h0102, 1'b0, 1'b0);
    bus.start = 1'b0;
    set_preset(16'h0999);
    expect_after("hold3", 3, S_RUN, 16'h0102, 1'b0, 1'b0);
    expect_after("tick1", 1, S_RUN, 16'h0101, 1'b0, 1'b0);
    expect_after("tick2", 4, S_RUN, 16'h0100, 1'b0, 1'b0);
    expect_after("tick3", 4, S_RUN, 16'h0059, 1'b0, 1'b0);
    expect_after("pre_done", 232, S_RUN, 16'h0001, 1'b0, 1'b0);
    expect_after("done", 4, S_DONE, 16'h0000, 1'b1, 1'b0);
    expect_after("done_hold", 6, S_DONE, 16'h0000, 1'b1, 1'b0);

    // Minute wrap 10:00 -> 09:59, started from DONE.
    set_preset(16'h1000);
    bus.start = 1'b1;
    expect_after("wrap_load", 1, S_RUN, 16'h1000, 1'b0, 1'b0);
    bus.start = 1'b0;
    expect_after("wrap_hold", 3, S_RUN, 16'h1000, 1'b0, 1'b0);
    expect_after("wrap", 1, S_RUN, 16'h0959, 1'b0, 1'b0);
    bus.clear = 1'b1;
    expect_after("clr1", 1, S_IDLE, 16'h0000, 1'b0, 1'b0);
    bus.clear = 1'b0;

    // Pause mid-second, hold, then resume to finish the remaining counts.
    set_preset(16'h0010);
    bus.start = 1'b1;
    expect_after("p_load", 1, S_RUN, 16'h0010, 1'b0, 1'b0);
    bus.start = 1'b0;
    expect_after("p_t2", 8, S_RUN, 16'h0008, 1'b0, 1'b0);
    expect_after("p_pre", 2, S_RUN, 16'h0008, 1'b0, 1'b0);
    bus.pause = 1'b1;
    expect_after("p_pause", 1, S_PAUSE, 16'h0008, 1'b0, 1'b0);
    expect_after("p_ign", 1, S_PAUSE, 16'h0008, 1'b0, 1'b0);
    bus.pause = 1'b0;
    expect_after("p_hold", 19, S_PAUSE, 16'h0008, 1'b0, 1'b0);
    set_preset(16'h0509);
    bus.start = 1'b1;
    expect_after("p_resume", 1, S_RUN, 16'h0008, 1'b0, 1'b0);
    bus.start = 1'b0;
    expect_after("p_r1", 1, S_RUN, 16'h0008, 1'b0, 1'b0);
    expect_after("p_r2", 1, S_RUN, 16'h0007, 1'b0, 1'b0);

    // start in RUN is ignored; start with pause pauses.
    bus.start = 1'b1;
    expect_after("run_start", 1, S_RUN, 16'h0007, 1'b0, 1'b0);
    bus.pause = 1'b1;
    expect_after("run_sp", 1, S_PAUSE, 16'h0007, 1'b0, 1'b0);
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.clear = 1'b1;
    expect_after("clr2", 1, S_IDLE, 16'h0000, 1'b0, 1'b0);
    bus.clear = 1'b0;

    // Invalid and zero presets.
    set_preset(16'h0060);
    bus.start = 1'b1;
    expect_after("inv", 1, S_IDLE, 16'h0000, 1'b0, 1'b1);
    bus.start = 1'b0;
    expect_after("inv_end", 1, S_IDLE, 16'h0000, 1'b0, 1'b0);
    set_preset(16'h0000);
    bus.start = 1'b1;
    expect_after("zero", 1, S_DONE, 16'h0000, 1'b1, 1'b0);
    set_preset(16'h000A);
    expect_after("inv_done", 1, S_DONE, 16'h0000, 1'b1, 1'b1);
    bus.start = 1'b0;

    // clear with start in the cycle a tick is due.
    set_preset(16'h0005);
    bus.start = 1'b1;
    expect_after("c_load", 1, S_RUN, 16'h0005, 1'b0, 1'b0);
    bus.start = 1'b0;
    expect_after("c_pre", 3, S_RUN, 16'h0005, 1'b0, 1'b0);
    bus.clear = 1'b1;
    bus.start = 1'b1;
    expect_after("c_clr", 1, S_IDLE, 16'h0000, 1'b0, 1'b0);
    bus.clear = 1'b0;
    bus.start = 1'b0;

    // Asynchronous reset mid-RUN, inputs ignored while held.
    set_preset(16'h0130);
    bus.start = 1'b1;
    expect_after("r_load", 1, S_RUN, 16'h0130, 1'b0, 1'b0);
    bus.start = 1'b0;
    tick_n(2);
    #2;
    rst_n = 1'b0;
    #1;
    push("r_async", S_IDLE, 16'h0000, 1'b0, 1'b0);
    pop_check();
    bus.start = 1'b1;
    expect_after("r_ign", 1, S_IDLE, 16'h0000, 1'b0, 1'b0);
    bus.start = 1'b0;
    #3;
    rst_n = 1'b1;
    expect_after("r_rel", 1, S_IDLE, 16'h0000, 1'b0, 1'b0);
    bus.start = 1'b1;
    expect_after("r_run", 1, S_RUN, 16'h0130, 1'b0, 1'b0);
    bus.start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
